apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_addr_decoder.sv | 25 ++
 rtl/apb_master.sv | 173 +++++++++++++++++
 tb/tb_apb_master.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Slave index lives in req_addr[15:12]; the low 12 bits are the in-slave offset.
    localparam int SLV_IDX_MSB = 15;
    localparam int SLV_IDX_LSB = 12;
    localparam int SLV_IDX_W   = SLV_IDX_MSB - SLV_IDX_LSB + 1;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WAIT_CNT_MIN_W  = 8;

    // Wait counter is never narrower than 8 bits, wider if TIMEOUT needs it.
    function automatic int wait_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < WAIT_CNT_MIN_W) ? WAIT_CNT_MIN_W : w;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Slave-index decode: index field -> one-hot PSEL pattern, or a decode error
// when the index names a slave that does not exist.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int NUM_SLV = 4
)(
    input  logic [SLV_IDX_W-1:0] slv_idx,
    output logic [NUM_SLV-1:0]   sel,
    output logic                 dec_err
);

    // Exactly one select bit for an in-range index, none plus an error otherwise.
    always_comb begin
        sel     = '0;
        dec_err = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (int'(slv_idx) == i) begin
                sel[i]  = 1'b1;
                dec_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: takes one host request at a time, runs the
// SETUP/ACCESS handshake towards the addressed slave and returns a one-cycle
// response pulse. Bad slave indices and stuck slaves are reported via rsp_err.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | req_ready high, waiting for a host request
//   SETUP  | PSEL driven, PENABLE low, address/data/direction presented
//   ACCESS | PENABLE high, waiting for PREADY or wait-counter timeout
//   RESP   | rsp_valid pulse, bus released
module apb_master
    import apb_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic [31:0]        PADDR,
    output logic [31:0]        PWDATA,
    output logic               PWRITE,
    output logic [NUM_SLV-1:0] PSEL,
    output logic               PENABLE,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY
);

    localparam int              CNT_W    = wait_cnt_width(TIMEOUT);
    // The abort fires in the ACCESS cycle that would push the count to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e          state_q,     state_d;
    logic [NUM_SLV-1:0]  psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic [31:0]         paddr_q,     paddr_d;
    logic [31:0]         pwdata_q,    pwdata_d;
    logic                pwrite_q,    pwrite_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic [NUM_SLV-1:0]  dec_sel;
    logic                dec_err;

    apb_addr_decoder #(
        .NUM_SLV (NUM_SLV)
    ) u_dec (
        .slv_idx (req_addr[SLV_IDX_MSB:SLV_IDX_LSB]),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
                if (req_valid) begin
                    if (dec_err) begin
                        // No bus activity for a non-existent slave; answer straight away.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = SETUP;
                        psel_d   = dec_sel;
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                        pwrite_d = req_write;
                        cnt_d    = '0;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end

            ACCESS: begin
                // PREADY wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    cnt_d       = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered bus/response outputs; reset clears everything at once.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers compared against a transaction-level reference model.
module tb_apb_master;

    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 255;
    localparam int NEVER   = 100000;

    logic               PCLK = 1'b0;
    logic               PRESET = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_write = 1'b0;
    logic [31:0]        req_addr = '0;
    logic [31:0]        req_wdata = '0;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic [31:0]        PADDR;
    logic [31:0]        PWDATA;
    logic               PWRITE;
    logic [NUM_SLV-1:0] PSEL;
    logic               PENABLE;
    logic [31:0]        PRDATA;
    logic               PREADY;

    int checks = 0;
    int errors = 0;

    apb_master #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave data source: written words are remembered, unwritten ones follow a pattern.
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int slv_wait = 0;

    function automatic logic [31:0] default_data(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Slave model: PREADY after slv_wait low ACCESS cycles, random noise elsewhere.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL != '0 && PENABLE) begin
                if (acc_cnt == slv_wait) begin
                    PREADY = 1'b1;
                    if (PWRITE) begin
                        slv_mem[PADDR] = PWDATA;
                        PRDATA = $urandom;
                    end else begin
                        PRDATA = slv_mem.exists(PADDR) ? slv_mem[PADDR] : default_data(PADDR);
                    end
                end else begin
                    PREADY = 1'b0;
                    PRDATA = $urandom;
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                PREADY = 1'($urandom_range(0, 1));
                PRDATA = $urandom;
            end
        end
    end

    // Transaction-level reference: outcome of one request from the address,
    // direction and the number of cycles the slave holds PREADY low.
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input int wt, output int lat, output logic err,
                                  output logic [31:0] rdata, output logic [NUM_SLV-1:0] psel);
        int idx;
        idx = int'(addr[15:12]);
        if (idx >= NUM_SLV) begin
            lat = 1; err = 1'b1; rdata = '0; psel = '0;
        end else if (wt >= TIMEOUT) begin
            lat = 2 + TIMEOUT; err = 1'b1; rdata = '0; psel = NUM_SLV'(1) << idx;
        end else begin
            lat = 3 + wt; err = 1'b0; psel = NUM_SLV'(1) << idx;
            if (wr) begin
                rdata = '0;
                ref_mem[addr] = wdata;
            end else begin
                rdata = ref_mem.exists(addr) ? ref_mem[addr] : default_data(addr);
            end
        end
    endfunction

    // Drives one request and records what the DUT did; protocol slips are counted in bad.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wt, output int lat, output logic [31:0] rdata, output logic err,
                           output logic [NUM_SLV-1:0] setup_psel, output logic setup_pen,
                           output int bad);
        bit acc;
        int n;
        lat = -1; rdata = 'x; err = 1'bx; setup_psel = 'x; setup_pen = 1'bx; bad = 0;
        acc = 0;
        slv_wait = wt;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 8; i++) begin
            if (req_ready) begin
                acc = 1;
                break;
            end
            @(negedge PCLK);
        end
        @(posedge PCLK);
        #1 req_valid = 1'b0;
        if (!acc) return;
        n = 0;
        for (int i = 0; i < TIMEOUT + 20; i++) begin
            @(negedge PCLK);
            n++;
            if ($countones(PSEL) > 1) bad++;
            if (PENABLE && PSEL == '0) bad++;
            if (PSEL != '0 && (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata)) bad++;
            if (n == 1) begin
                setup_psel = PSEL;
                setup_pen  = PENABLE;
            end
            if (rsp_valid) begin
                lat = n; rdata = rsp_rdata; err = rsp_err;
                if (PSEL != '0 || PENABLE) bad++;
                break;
            end
            if (n >= 2 && (PSEL !== setup_psel || !PENABLE)) bad++;
        end
    endtask

    task automatic test_reset();
        #1 PRESET = 1'b0;
        #2;
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        checks++;
        if ({PADDR, PWDATA, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected zeros", PADDR, PWDATA, rsp_rdata);
        end
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_write_basic();
        int lat, e_lat, bad; logic [31:0] rd, e_rd; logic er, e_er, spen;
        logic [NUM_SLV-1:0] sps, e_ps;
        model(1'b1, 32'h0000_1004, 32'h0000_1234, 1, e_lat, e_er, e_rd, e_ps);
        run_txn(1'b1, 32'h0000_1004, 32'h0000_1234, 1, lat, rd, er, sps, spen, bad);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", lat); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
        checks++;
        if (sps !== 4'b0010 || spen !== 1'b0) begin
            errors++; $display("FAIL wr_setup: psel %b penable %b expected 0010 0", sps, spen);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wr_protocol: got %0d violations expected 0", bad); end
    endtask

    task automatic test_read_basic();
        int lat, e_lat, bad; logic [31:0] rd, e_rd; logic er, e_er, spen;
        logic [NUM_SLV-1:0] sps, e_ps;
        slv_mem[32'h0000_0008] = 32'hDEAD_BEEF;
        ref_mem[32'h0000_0008] = 32'hDEAD_BEEF;
        model(1'b0, 32'h0000_0008, 32'h0, 0, e_lat, e_er, e_rd, e_ps);
        run_txn(1'b0, 32'h0000_0008, 32'h0, 0, lat, rd, er, sps, spen, bad);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++; $display("FAIL rd_data: got %h err %b expected deadbeef err 0", rd, er);
        end
        checks++;
        if (sps !== 4'b0001 || bad !== 0) begin
            errors++; $display("FAIL rd_setup: psel %b bad %0d expected 0001 0", sps, bad);
        end
    endtask

    task automatic test_decode_err();
        int lat, bad; logic [31:0] rd; logic er, spen; logic [NUM_SLV-1:0] sps;
        run_txn(1'b0, 32'h0000_5000, 32'h0, 0, lat, rd, er, sps, spen, bad);
        checks++;
        if (lat !== 1 || er !== 1'b1) begin
            errors++; $display("FAIL decerr_rsp: lat %0d err %b expected 1 1", lat, er);
        end
        checks++;
        if (rd !== 32'h0 || sps !== '0 || bad !== 0) begin
            errors++; $display("FAIL decerr_bus: rdata %h psel %b bad %0d expected 0 0 0", rd, sps, bad);
        end
    endtask

    task automatic test_timeout();
        int lat, e_lat, bad; logic [31:0] rd, e_rd; logic er, e_er, spen;
        logic [NUM_SLV-1:0] sps, e_ps;
        model(1'b0, 32'h0000_2010, 32'h0, NEVER, e_lat, e_er, e_rd, e_ps);
        run_txn(1'b0, 32'h0000_2010, 32'h0, NEVER, lat, rd, er, sps, spen, bad);
        checks++;
        if (lat !== e_lat || er !== e_er || rd !== e_rd) begin
            errors++; $display("FAIL timeout: lat %0d err %b rdata %h expected %0d %b %h", lat, er, rd, e_lat, e_er, e_rd);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL timeout_bus: got %0d violations expected 0", bad); end
        // Slave answers in the very cycle the counter would expire: must succeed.
        model(1'b0, 32'h0000_3018, 32'h0, TIMEOUT - 1, e_lat, e_er, e_rd, e_ps);
        run_txn(1'b0, 32'h0000_3018, 32'h0, TIMEOUT - 1, lat, rd, er, sps, spen, bad);
        checks++;
        if (lat !== e_lat || er !== e_er || rd !== e_rd) begin
            errors++; $display("FAIL timeout_edge: lat %0d err %b rdata %h expected %0d %b %h", lat, er, rd, e_lat, e_er, e_rd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, e_lat, bad, seen; logic [31:0] rd, e_rd; logic er, e_er, spen;
        logic [NUM_SLV-1:0] sps, e_ps;
        slv_wait = NEVER;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_3020;
        @(posedge PCLK);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        checks++;
        if (PENABLE !== 1'b1) begin errors++; $display("FAIL rstmid_access: penable %b expected 1", PENABLE); end
        #1 PRESET = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, rsp_rdata} !== '0) begin
            errors++; $display("FAIL rstmid_clear: psel %b penable %b paddr %h rsp_valid %b", PSEL, PENABLE, PADDR, rsp_valid);
        end
        @(negedge PCLK);
        PRESET = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rstmid_norsp: got %0d pulses expected 0", seen); end
        model(1'b1, 32'h0000_2024, 32'hCAFE_0001, 2, e_lat, e_er, e_rd, e_ps);
        run_txn(1'b1, 32'h0000_2024, 32'hCAFE_0001, 2, lat, rd, er, sps, spen, bad);
        checks++;
        if (lat !== e_lat || er !== e_er || bad !== 0) begin
            errors++; $display("FAIL rstmid_next: lat %0d err %b bad %0d expected %0d %b 0", lat, er, bad, e_lat, e_er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] exp_d [3];
        logic [31:0] got_d [3];
        logic got_e [3];
        int acc_t [3];
        int k, nrsp, lat; logic e_er; logic [NUM_SLV-1:0] e_ps;
        bit took;
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_1104; addrs[2] = 32'h0000_2108;
        for (int j = 0; j < 3; j++) begin
            slv_mem[addrs[j]] = 32'h1111_0000 + 32'(j) * 32'h0101_0101;
            ref_mem[addrs[j]] = 32'h1111_0000 + 32'(j) * 32'h0101_0101;
            model(1'b0, addrs[j], 32'h0, 0, lat, e_er, exp_d[j], e_ps);
            got_d[j] = 'x; got_e[j] = 1'bx; acc_t[j] = -100;
        end
        slv_wait = 0;
        k = 0; nrsp = 0;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addrs[0]; req_wdata = '0;
        for (int i = 0; i < 40 && nrsp < 3; i++) begin
            took = 0;
            if (req_valid && req_ready && k < 3) begin acc_t[k] = i; k++; took = 1; end
            if (rsp_valid) begin got_d[nrsp] = rsp_rdata; got_e[nrsp] = rsp_err; nrsp++; end
            if (nrsp == 3) break;
            @(posedge PCLK);
            #1;
            if (took) begin
                if (k < 3) req_addr = addrs[k];
                else req_valid = 1'b0;
            end
            @(negedge PCLK);
        end
        req_valid = 1'b0;
        checks++;
        if (k !== 3 || nrsp !== 3) begin errors++; $display("FAIL b2b_count: accepts %0d rsps %0d expected 3 3", k, nrsp); end
        checks++;
        if (acc_t[1] - acc_t[0] !== 4 || acc_t[2] - acc_t[1] !== 4) begin
            errors++; $display("FAIL b2b_spacing: got %0d %0d expected 4 4", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (got_d[j] !== exp_d[j] || got_e[j] !== 1'b0) begin
                errors++; $display("FAIL b2b_data%0d: got %h err %b expected %h err 0", j, got_d[j], got_e[j], exp_d[j]);
            end
        end
    endtask

    task automatic test_random();
        int lat, e_lat, bad, wt; logic [31:0] rd, e_rd, addr, wd; logic er, e_er, spen, wr;
        logic [NUM_SLV-1:0] sps, e_ps;
        for (int t = 0; t < 30; t++) begin
            addr = {16'h0, 4'($urandom_range(0, 5)), 12'($urandom_range(0, 7) * 4)};
            wr   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            wt   = $urandom_range(0, 4);
            model(wr, addr, wd, wt, e_lat, e_er, e_rd, e_ps);
            run_txn(wr, addr, wd, wt, lat, rd, er, sps, spen, bad);
            checks++;
            if (lat !== e_lat || er !== e_er) begin
                errors++; $display("FAIL rnd%0d_timing: lat %0d err %b expected %0d %b", t, lat, er, e_lat, e_er);
            end
            checks++;
            if (rd !== e_rd) begin
                errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", t, rd, e_rd);
            end
            checks++;
            if (sps !== e_ps || bad !== 0 || (e_ps != '0 && spen !== 1'b0)) begin
                errors++; $display("FAIL rnd%0d_bus: psel %b penable %b bad %0d expected %b 0 0", t, sps, spen, bad, e_ps);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_decode_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
